// File: rtl/hex_display_scanner.sv
// Multiplexed hex display scanner: walks NUM_DIGITS slots of REFRESH_DIV clocks, driving one
// shared decoder nibble plus active-low anodes, with frame-aligned double buffering.
module hex_display_scanner #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_GAP   = 500
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    x3,
   output logic                    x2,
   output logic                    x1,
   output logic                    x0,
   output logic                    En,
   output logic [NUM_DIGITS-1:0]   dig_sel,
   output logic                    frame_done
);

   localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int OW       = $clog2(REFRESH_DIV);
   localparam int SHOW_LEN = REFRESH_DIV - BLANK_GAP;
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [OW-1:0] OFF_LAST = OW'(REFRESH_DIV - 1);

   // Position is held as (slot index, offset in slot); together they form the frame position
   // to be presented at the next edge.
   logic [IW-1:0]           idx;
   logic [OW-1:0]           off;
   logic [4*NUM_DIGITS-1:0] pending;
   logic [4*NUM_DIGITS-1:0] display;
   logic                    pend_valid;
   logic [3:0]              nib;
   logic [3:0]              x_q;
   logic [NUM_DIGITS-1:0]   tail_zero;
   logic                    zero_run;
   logic                    show;
   logic                    last;
   logic                    lit;

   // tail_zero[i]: displayed digits NUM_DIGITS-1 down to i are all zero
   always_comb begin
      zero_run  = 1'b1;
      tail_zero = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run     = zero_run & (display[4*i +: 4] == 4'h0);
         tail_zero[i] = zero_run;
      end
      nib  = display[4*idx +: 4];
      show = int'(off) < SHOW_LEN;
      last = (idx == IDX_LAST) && (off == OFF_LAST);
      lit  = digit_en[idx] & ~(blank_lz & (idx != '0) & tail_zero[idx]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx        <= '0;
         off        <= '0;
         pending    <= '0;
         display    <= '0;
         pend_valid <= 1'b0;
         x_q        <= 4'h0;
         En         <= 1'b0;
         dig_sel    <= '1;
         frame_done <= 1'b0;
      end else begin
         x_q        <= nib;
         En         <= show & lit;
         dig_sel    <= '1;
         if (show) dig_sel[idx] <= ~lit;
         frame_done <= last;

         if (off == OFF_LAST) begin
            off <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            off <= off + 1'b1;
         end

         if (load) pending <= value;
         // A load on the frame's last cycle bypasses the pending buffer entirely
         if (last) begin
            if (load)            display <= value;
            else if (pend_valid) display <= pending;
            pend_valid <= 1'b0;
         end else if (load) begin
            pend_valid <= 1'b1;
         end
      end
   end

   assign {x3, x2, x1, x0} = x_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: per-cycle scoreboard against a behavioural model, table-driven
// frame checks, and hand-written sequences for reset, load timing and buffering corners.
module tb_hex_display_scanner;

   localparam int N = 4;
   localparam int R = 8;
   localparam int G = 2;
   localparam int T = N * R;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic        blank_lz = 1'b0;
   logic [15:0] value = 16'h0;
   logic [3:0]  digit_en = 4'hF;
   logic        x3, x2, x1, x0, En, frame_done;
   logic [3:0]  dig_sel;

   typedef struct packed {
      logic [3:0] x;
      logic       en;
      logic [3:0] sel;
      logic       fd;
   } exp_t;

   typedef struct {
      logic [15:0] val;
      logic        blz;
      logic [3:0]  den;
      logic [3:0]  lit_mask;
   } vec_t;

   exp_t        sb[$];
   int          checks = 0;
   int          failures = 0;
   int          m_p = 0;
   logic [15:0] m_disp = 16'h0;
   logic [15:0] m_pend = 16'h0;
   logic        m_pv = 1'b0;

   always #5 clk = ~clk;

   hex_display_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(R), .BLANK_GAP(G)) dut (
      .clk(clk), .reset(reset), .value(value), .load(load), .blank_lz(blank_lz),
      .digit_en(digit_en), .x3(x3), .x2(x2), .x1(x1), .x0(x0), .En(En),
      .dig_sel(dig_sel), .frame_done(frame_done)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Behavioural model of one rising edge; returns the outputs expected after that edge.
   task automatic model(input logic rst, input logic ld, input logic [15:0] v, output exp_t e);
      int   i;
      int   o;
      logic lit;
      e     = '0;
      e.sel = 4'hF;
      if (rst) begin
         m_p = 0; m_disp = 16'h0; m_pend = 16'h0; m_pv = 1'b0;
      end else begin
         i   = m_p / R;
         o   = m_p % R;
         e.x = m_disp[4*i +: 4];
         lit = digit_en[i] && !(blank_lz && i > 0 && (m_disp >> (4*i)) == 16'h0);
         if (o < R - G) begin
            e.en     = lit;
            e.sel[i] = !lit;
         end
         e.fd = (m_p == T - 1);
         if (m_p == T - 1) begin
            if (ld) m_disp = v;
            else if (m_pv) m_disp = m_pend;
            m_pv = 1'b0;
         end else if (ld) begin
            m_pv = 1'b1;
         end
         if (ld) m_pend = v;
         m_p = (m_p + 1) % T;
      end
   endtask

   task automatic cyc(input logic rst, input logic ld, input logic [15:0] v);
      exp_t e;
      exp_t q;
      exp_t got;
      reset = rst; load = ld; value = v;
      model(rst, ld, v, e);
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = {{x3, x2, x1, x0}, En, dig_sel, frame_done};
      q   = sb.pop_front();
      checks++;
      if (got !== q) begin
         failures++;
         $display("FAIL cycle_out p=%0d: got x=%h en=%b sel=%b fd=%b expected x=%h en=%b sel=%b fd=%b",
                  (m_p + T - 1) % T, got.x, got.en, got.sel, got.fd, q.x, q.en, q.sel, q.fd);
      end
      load = 1'b0;
   endtask

   // One full frame from p=0: nibble, En and anodes at each slot start, frame_done position, lit count.
   task automatic scan(output logic [15:0] xs, output logic [3:0] litm, output logic [15:0] sels,
                       output int fdpos, output int encnt);
      xs = 16'h0; litm = 4'h0; sels = 16'h0; fdpos = -1; encnt = 0;
      for (int c = 0; c < T; c++) begin
         cyc(1'b0, 1'b0, 16'h0);
         if (c % R == 0) begin
            xs[4*(c/R) +: 4]   = {x3, x2, x1, x0};
            litm[c/R]          = En;
            sels[4*(c/R) +: 4] = dig_sel;
         end
         if (En) encnt++;
         if (frame_done) fdpos = c;
      end
   endtask

   task automatic to_frame();
      logic f;
      f = 1'b0;
      for (int i = 0; i < 2*T && !f; i++) begin
         cyc(1'b0, 1'b0, 16'h0);
         f = frame_done;
      end
      check("frame_sync", f, 1'b1);
   endtask

   initial begin
      vec_t        tbl[6];
      logic [15:0] xs;
      logic [15:0] sels;
      logic [3:0]  litm;
      int          fdpos;
      int          encnt;
      int          fdp;
      int          xnz;
      int          fdc;

      tbl[0] = '{16'h12AF, 1'b0, 4'hF,    4'b1111};
      tbl[1] = '{16'h0050, 1'b1, 4'hF,    4'b0011};
      tbl[2] = '{16'h0000, 1'b1, 4'hF,    4'b0001};
      tbl[3] = '{16'h1111, 1'b0, 4'b1011, 4'b1011};
      tbl[4] = '{16'h0A00, 1'b1, 4'b0110, 4'b0110};
      tbl[5] = '{16'h0F00, 1'b0, 4'hF,    4'b1111};

      // Reset held, then first edge after release is p=0
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 16'h0);
      check("reset_outs", {x3, x2, x1, x0, En, dig_sel, frame_done}, 10'b0000_0_1111_0);
      cyc(1'b0, 1'b0, 16'h0);
      check("first_sel", dig_sel, 4'b1110);
      check("first_x", {x3, x2, x1, x0}, 4'h0);

      // Load mid-frame: current frame stays 0000, new word appears next frame
      cyc(1'b0, 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 16'h0);
      cyc(1'b0, 1'b1, 16'h12AF);
      fdp = -1; xnz = 0;
      for (int p = 4; p < T; p++) begin
         cyc(1'b0, 1'b0, 16'h0);
         if ({x3, x2, x1, x0} != 4'h0) xnz++;
         if (frame_done) fdp = p;
      end
      check("frame0_unchanged", xnz, 0);
      check("frame_done_pos", fdp, T - 1);
      scan(xs, litm, sels, fdpos, encnt);
      check("load_digits", xs, 16'h12AF);
      check("load_anodes", sels, 16'h7BDE);
      check("load_lit_cycles", encnt, N * (R - G));
      check("load_fd_pos", fdpos, T - 1);

      // Load on the last cycle overrides a pending word, which is then discarded
      cyc(1'b0, 1'b1, 16'h2222);
      for (int p = 1; p < T - 1; p++) cyc(1'b0, 1'b0, 16'h0);
      cyc(1'b0, 1'b1, 16'h1111);
      check("bypass_fd", frame_done, 1'b1);
      scan(xs, litm, sels, fdpos, encnt);
      check("bypass_digits", xs, 16'h1111);
      scan(xs, litm, sels, fdpos, encnt);
      check("pend_cleared", xs, 16'h1111);

      for (int k = 0; k < 6; k++) begin
         blank_lz = tbl[k].blz;
         digit_en = tbl[k].den;
         cyc(1'b0, 1'b1, tbl[k].val);
         to_frame();
         scan(xs, litm, sels, fdpos, encnt);
         check($sformatf("tbl%0d_lit", k), litm, tbl[k].lit_mask);
         check($sformatf("tbl%0d_digits", k), xs, tbl[k].val);
         check($sformatf("tbl%0d_fd", k), fdpos, T - 1);
      end
      blank_lz = 1'b0;
      digit_en = 4'hF;

      // Reset mid-frame at p=17: no pulse, restart at p=0 with display cleared
      for (int i = 0; i < T && m_p != 17; i++) cyc(1'b0, 1'b0, 16'h0);
      check("reach_p17", m_p, 17);
      fdc = 0;
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'b0, 16'h0);
         if (frame_done) fdc++;
      end
      check("midreset_no_fd", fdc, 0);
      check("midreset_sel", dig_sel, 4'hF);
      cyc(1'b0, 1'b0, 16'h0);
      check("restart_sel", dig_sel, 4'b1110);
      check("restart_x", {x3, x2, x1, x0}, 4'h0);
      to_frame();
      scan(xs, litm, sels, fdpos, encnt);
      check("restart_display", xs, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
